// File: rtl/tile_palette_arbiter.sv
// Round-robin arbiter sharing one combinational palette lookup among NREQ pixel requesters.
// Optional build macro TILE_PAL_ARB_PRIO0_EN gives requester 0 fixed top priority.
module tile_palette_arbiter #(
  parameter  int NREQ  = 4,
  parameter  int IDX_W = 4,
  localparam int IDW   = $clog2(NREQ)
) (
  input  logic                   Clk,
  input  logic                   Reset_n,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [NREQ*IDX_W-1:0]  req_index,
  output logic [NREQ-1:0]        req_ready,
  output logic [IDX_W-1:0]       pal_index,
  input  logic [3:0]             pal_red,
  input  logic [3:0]             pal_green,
  input  logic [3:0]             pal_blue,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [IDW-1:0]         rsp_id,
  output logic [3:0]             rsp_red,
  output logic [3:0]             rsp_green,
  output logic [3:0]             rsp_blue
);

`ifdef TILE_PAL_ARB_PRIO0_EN
  localparam bit       PRIO0   = 1'b1;
  localparam int       LB      = 1;
  localparam [IDW-1:0] PTR_RST = IDW'(1);
`else
  localparam bit       PRIO0   = 1'b0;
  localparam int       LB      = 0;
  localparam [IDW-1:0] PTR_RST = '0;
`endif

  logic [IDW-1:0] ptr;
  logic [IDW-1:0] ptr_next;
  logic [IDW-1:0] grant_id;
  logic [IDW-1:0] hi_id;
  logic [IDW-1:0] lo_id;
  logic           hi_found;
  logic           lo_found;
  logic           grant_any;
  logic           can_accept;
  logic           hs;

  assign can_accept = !rsp_valid || rsp_ready;

  // Candidates at or above ptr beat those below it; descending scan keeps the lowest of each group.
  always_comb begin
    hi_found  = 1'b0;
    lo_found  = 1'b0;
    hi_id     = '0;
    lo_id     = '0;
    grant_any = 1'b0;
    grant_id  = '0;
    for (int i = NREQ - 1; i >= LB; i--) begin
      if (req_valid[i]) begin
        if (i >= int'(ptr)) begin
          hi_found = 1'b1;
          hi_id    = IDW'(i);
        end else begin
          lo_found = 1'b1;
          lo_id    = IDW'(i);
        end
      end
    end
    if (PRIO0 && req_valid[0]) begin
      grant_any = 1'b1;
      grant_id  = '0;
    end else if (hi_found) begin
      grant_any = 1'b1;
      grant_id  = hi_id;
    end else if (lo_found) begin
      grant_any = 1'b1;
      grant_id  = lo_id;
    end
  end

  assign hs = grant_any && can_accept && Reset_n;

  always_comb begin
    req_ready = '0;
    pal_index = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_ready[i] = hs && (grant_id == IDW'(i));
      if (req_ready[i]) pal_index = req_index[i*IDX_W +: IDX_W];
    end
  end

  // In priority mode a grant to requester 0 leaves the rotation for 1..NREQ-1 untouched.
  always_comb begin
    ptr_next = ptr;
    if (hs && !(PRIO0 && grant_id == '0)) begin
      if (grant_id == IDW'(NREQ - 1)) ptr_next = PTR_RST;
      else                           ptr_next = grant_id + IDW'(1);
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      ptr       <= PTR_RST;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_red   <= '0;
      rsp_green <= '0;
      rsp_blue  <= '0;
    end else begin
      ptr <= ptr_next;
      if (hs) begin
        rsp_valid <= 1'b1;
        rsp_id    <= grant_id;
        rsp_red   <= pal_red;
        rsp_green <= pal_green;
        rsp_blue  <= pal_blue;
      end else if (rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_tile_palette_arbiter.sv
// Testbench for tile_palette_arbiter: directed steps then random traffic against a behavioural model.
module tb_tile_palette_arbiter;
  localparam int NREQ  = 4;
  localparam int IDX_W = 4;
`ifdef TILE_PAL_ARB_PRIO0_EN
  localparam bit PRIO0 = 1'b1;
`else
  localparam bit PRIO0 = 1'b0;
`endif

  logic                  clk = 1'b0;
  logic                  resetN;
  logic [NREQ-1:0]       reqValid;
  logic [NREQ*IDX_W-1:0] reqIndex;
  logic [NREQ-1:0]       reqReady;
  logic [IDX_W-1:0]      palIndex;
  logic [3:0]            palRed, palGreen, palBlue;
  logic                  rspValid;
  logic                  rspReady;
  logic [1:0]            rspId;
  logic [3:0]            rspRed, rspGreen, rspBlue;

  logic [11:0] paletteMem [16];

  int checks = 0;
  int errors = 0;

  int         mPtr      = 0;
  bit         mRspValid = 1'b0;
  int         mRspId    = 0;
  logic [11:0] mRgb     = '0;

  always #5 clk = ~clk;

  assign {palRed, palGreen, palBlue} = paletteMem[palIndex];

  tile_palette_arbiter #(.NREQ(NREQ), .IDX_W(IDX_W)) dut (
    .Clk(clk), .Reset_n(resetN),
    .req_valid(reqValid), .req_index(reqIndex), .req_ready(reqReady),
    .pal_index(palIndex), .pal_red(palRed), .pal_green(palGreen), .pal_blue(palBlue),
    .rsp_valid(rspValid), .rsp_ready(rspReady), .rsp_id(rspId),
    .rsp_red(rspRed), .rsp_green(rspGreen), .rsp_blue(rspBlue)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Grant chosen from the rules: requester order starting at the pointer, modulo the ring size.
  function automatic int modelGrant(input logic [NREQ-1:0] v, input bit rr, input bit rn);
    if (!rn || !(!mRspValid || rr)) return -1;
    if (PRIO0) begin
      if (v[0]) return 0;
      for (int k = 0; k < NREQ - 1; k++) begin
        int c = 1 + ((mPtr - 1 + k) % (NREQ - 1));
        if (v[c]) return c;
      end
    end else begin
      for (int k = 0; k < NREQ; k++) begin
        int c = (mPtr + k) % NREQ;
        if (v[c]) return c;
      end
    end
    return -1;
  endfunction

  task automatic applyStimulus(input logic [NREQ-1:0] v, input logic [NREQ*IDX_W-1:0] idx,
                               input bit rr, input bit rn);
    int g;
    logic [NREQ-1:0]  expReady;
    logic [IDX_W-1:0] expIdx;
    @(negedge clk);
    reqValid = v;
    reqIndex = idx;
    rspReady = rr;
    resetN   = rn;
    #1;
    g        = modelGrant(v, rr, rn);
    expReady = '0;
    expIdx   = '0;
    if (g >= 0) begin
      expReady[g] = 1'b1;
      expIdx      = idx[g*IDX_W +: IDX_W];
    end
    checkOutput("req_ready", reqReady, expReady);
    checkOutput("req_ready_onehot", $onehot0(reqReady), 1);
    checkOutput("pal_index", palIndex, expIdx);
    @(posedge clk);
    if (!rn) begin
      mPtr      = PRIO0 ? 1 : 0;
      mRspValid = 1'b0;
      mRspId    = 0;
      mRgb      = '0;
    end else if (g >= 0) begin
      mRspValid = 1'b1;
      mRspId    = g;
      mRgb      = paletteMem[expIdx];
      if (PRIO0) begin
        if (g != 0) mPtr = (g % (NREQ - 1)) + 1;
      end else begin
        mPtr = (g + 1) % NREQ;
      end
    end else if (rr) begin
      mRspValid = 1'b0;
    end
    #1;
    checkOutput("rsp_valid", rspValid, mRspValid);
    checkOutput("rsp_id", rspId, mRspId);
    checkOutput("rsp_rgb", {rspRed, rspGreen, rspBlue}, mRgb);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) paletteMem[i] = 12'h0F0;
    paletteMem[1] = 12'h00F;
    reqValid = '0;
    reqIndex = '0;
    rspReady = 1'b0;
    resetN   = 1'b0;

    $display("[TB] reset");
    applyStimulus(4'b1111, 16'h1513, 1'b1, 1'b0);
    applyStimulus(4'b0000, 16'h0000, 1'b1, 1'b0);

    $display("[TB] single requester");
    applyStimulus(4'b0010, 16'h0010, 1'b1, 1'b1);
    applyStimulus(4'b0000, 16'h0000, 1'b1, 1'b1);

    $display("[TB] all four requesting");
    for (int i = 0; i < 5; i++) applyStimulus(4'b1111, 16'h1513, 1'b1, 1'b1);

    $display("[TB] backpressure");
    for (int i = 0; i < 3; i++) applyStimulus(4'b1111, 16'h1513, 1'b0, 1'b1);
    applyStimulus(4'b1111, 16'h1513, 1'b1, 1'b1);

    $display("[TB] reset with response pending");
    applyStimulus(4'b1111, 16'h1513, 1'b0, 1'b0);
    applyStimulus(4'b0100, 16'h1513, 1'b1, 1'b1);
    applyStimulus(4'b1111, 16'h1513, 1'b0, 1'b0);
    applyStimulus(4'b1111, 16'h1513, 1'b1, 1'b1);

    $display("[TB] requester 0 dropped");
    for (int i = 0; i < 4; i++) applyStimulus(4'b1110, 16'h1513, 1'b1, 1'b1);

    $display("[TB] idle");
    for (int i = 0; i < 5; i++) applyStimulus(4'b0000, 16'h1513, 1'b1, 1'b1);
    applyStimulus(4'b1111, 16'h1513, 1'b1, 1'b1);

    $display("[TB] random traffic");
    for (int i = 0; i < 16; i++) paletteMem[i] = 12'($urandom);
    for (int n = 0; n < 400; n++) begin
      logic [NREQ-1:0]       v;
      logic [NREQ*IDX_W-1:0] idx;
      bit                    rr;
      bit                    rn;
      v   = NREQ'($urandom);
      if ($urandom_range(0, 3) == 0) v = v & NREQ'($urandom);
      idx = (NREQ*IDX_W)'($urandom);
      rr  = ($urandom_range(0, 9) < 7);
      rn  = ($urandom_range(0, 49) != 0);
      applyStimulus(v, idx, rr, rn);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/tile_palette_arbiter.md
# tile_palette_arbiter

Shares one combinational 16-entry tile palette lookup among up to NREQ pixel requesters (background tile renderer, tank sprites, missiles, score overlay). Each cycle it grants at most one pending request with round-robin arbitration and drives that requester's 4-bit index to the palette. It registers the returned 12-bit RGB with the winner's ID on a valid/ready response port. The block sits between the per-object renderers and the VGA colour mux; the palette module itself stays outside the arbiter.

## Interface
- NREQ, 4, number of requesters (2..8)
- IDX_W, 4, palette index width
- Clk  in  1  system clock, all logic on rising edge
- Reset_n  in  1  synchronous, active-low reset
- req_valid  in  NREQ  per-requester request pending
- req_index  in  NREQ*IDX_W  packed indices, requester i at bits [i*IDX_W +: IDX_W]
- req_ready  out  NREQ  one-hot grant; handshake when req_valid[i] & req_ready[i]
- pal_index  out  IDX_W  index driven to the palette lookup
- pal_red, pal_green, pal_blue  in  4 each  palette colour for pal_index, combinational
- rsp_valid  out  1  response register holds a colour
- rsp_ready  in  1  consumer accepts response
- rsp_id  out  $clog2(NREQ)  requester that owns the response
- rsp_red, rsp_green, rsp_blue  out  4 each  registered colour

## Operation
- can_accept = !rsp_valid | rsp_ready. When can_accept = 0, req_ready = 0.
- Round-robin pointer ptr, width $clog2(NREQ):
  - Search starts at ptr and wraps modulo NREQ.
  - The first i with req_valid[i] = 1 gets req_ready[i] = 1. All other bits are 0.
  - On a handshake, ptr <= (granted + 1) mod NREQ. With no handshake, ptr holds.
- req_ready is combinational from req_valid, ptr and rsp state. Requesters must not make req_valid depend on req_ready.
- pal_index = req_index of the granted requester. With no grant, pal_index = 0.
- On a handshake:
  - rsp_valid <= 1.
  - rsp_id <= granted.
  - rsp_{red,green,blue} <= pal_{red,green,blue} sampled in the same cycle.
- rsp_ready = 1 with no new handshake: rsp_valid <= 0. Colour and ID registers hold their old values.
- rsp_valid = 1 and rsp_ready = 0: all response outputs hold stable, no grant.
- A requester that drops req_valid before it is granted loses nothing. There is no request memory.

## Timing
- Latency: handshake in cycle T, response valid in T+1.
- Throughput: 1 lookup per cycle while rsp_ready stays 1. Simultaneous drain and accept in the same cycle is required.
- Reset (Reset_n = 0 at a rising edge):
  - ptr = 0, rsp_valid = 0, rsp_id = 0, rsp_red/green/blue = 0.
  - req_ready = 0 during any cycle where Reset_n = 0.
- Reset mid-operation discards a pending response. The first grant after reset starts the search at requester 0.
- Wrap-around: when the last grant went to NREQ-1, the next search starts at 0.
- All NREQ requesting continuously with rsp_ready = 1 yields grant order 0,1,…,NREQ-1,0,…. No requester waits more than NREQ-1 grants.

## Configuration
- TILE_PAL_ARB_PRIO0_EN defined:
  - Requester 0 (display scanout) has fixed highest priority. It wins whenever req_valid[0] = 1 and can_accept = 1.
  - Requesters 1..NREQ-1 round-robin among themselves with ptr ranging 1..NREQ-1. After a grant to requester 0, ptr is unchanged.
  - Reset value of ptr becomes 1.
- Undefined: pure round-robin across all NREQ requesters, as described above.

## Test plan
Palette connected for all tests: index 1 → 0x00F; all other indices → 0x0F0. NREQ = 4. The checker verifies one-hot req_ready every cycle.
- Single requester: req_valid = 0010, index 1, rsp_ready = 1 → req_ready = 0010 in T; T+1 rsp_valid = 1, rsp_id = 1, RGB = 0,0,F.
- All four valid, indices 3,1,5,1, rsp_ready = 1 → rsp_id sequence 0,1,2,3,0. Colours 0F0, 00F, 0F0, 00F, 0F0. One response per cycle.
- Backpressure: response pending, rsp_ready = 0 for 3 cycles with req_valid = 1111 → req_ready = 0000 and rsp_* stable for 3 cycles. rsp_ready = 1 then accepts the next requester in the same cycle.
- Reset mid-operation: Reset_n = 0 for 1 cycle while rsp_valid = 1, then req_valid = 0100 → rsp_valid = 0 and all rsp_* = 0 after reset. The next grant goes to 2; if all valid, the grant goes to 0 first.
- With TILE_PAL_ARB_PRIO0_EN and req_valid = 1111 held → every grant goes to requester 0. Dropping req_valid[0] gives grant order 1,2,3,1.
- Idle: req_valid = 0000 for 5 cycles → pal_index = 0, req_ready = 0000, ptr unchanged, rsp_valid falls after drain.
